// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared types and constants for the scan test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Default number of scan flops in the chain driven by the sequencer
    localparam int SCAN_CHAIN_LEN_DEFAULT = 3;

    // Sequencer states: load, capture, unload, then present the response
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } scan_state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_ctrl
// Purpose  : Runs one scan pattern on a chain of CHAIN_LEN flops: serial
//            load of a parallel vector, one functional capture, serial
//            unload. The response is returned on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module scan_test_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CHAIN_LEN-1:0] start_vec,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_vec,
    output logic                 busy,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    scan_state_t            r_state;
    scan_state_t            w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CHAIN_LEN-1:0]   r_sreg;
    logic [CHAIN_LEN-1:0]   r_resp;
    logic [CHAIN_LEN-1:0]   w_resp_shift;
    logic                   w_cnt_last;

    assign w_cnt_last = (r_cnt == c_cnt_last);

    // Unload shift: newest scan_out bit enters at the bottom of the response
    generate
        if (CHAIN_LEN == 1) begin : g_resp_single
            assign w_resp_shift = scan_out;
        end else begin : g_resp_multi
            assign w_resp_shift = {r_resp[CHAIN_LEN-2:0], scan_out};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; each shift phase lasts exactly CHAIN_LEN cycles
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_next_state = SHIFT;
            SHIFT:   if (w_cnt_last)  w_next_state = CAPTURE;
            CAPTURE:                  w_next_state = UNLOAD;
            UNLOAD:  if (w_cnt_last)  w_next_state = DONE;
            DONE:    if (resp_ready)  w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // Counter and shift registers; MSB of the load vector is shifted first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sreg <= '0;
            r_resp <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_sreg <= start_vec;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_sreg <= r_sreg << 1;
                    r_cnt  <= w_cnt_last ? '0 : r_cnt + c_cnt_one;
                end
                CAPTURE: begin
                    r_cnt <= '0;
                end
                UNLOAD: begin
                    r_resp <= w_resp_shift;
                    r_cnt  <= w_cnt_last ? '0 : r_cnt + c_cnt_one;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never on inputs
    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign scan_en     = (r_state == SHIFT) || (r_state == UNLOAD);
    assign scan_in     = (r_state == SHIFT) ? r_sreg[CHAIN_LEN-1] : 1'b0;
    assign resp_valid  = (r_state == DONE);
    assign resp_vec    = r_resp;

endmodule : scan_test_ctrl
`default_nettype wire

// File: tb/tb_scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_test_ctrl
// Purpose  : Self-checking bench for scan_test_ctrl with a behavioural
//            scan chain and directed plus random patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_test_ctrl;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] start_vec;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_vec;
    logic         busy;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;

    // Behavioural chain: flop 0 is nearest scan_in
    logic [N-1:0] chain_q;
    logic [N-1:0] d_val;
    logic         d_fb;
    logic [N-1:0] d_in;

    int n_vec = 0;
    int n_err = 0;

    scan_test_ctrl #(.CHAIN_LEN(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .start_vec  (start_vec),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_vec   (resp_vec),
        .busy       (busy),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out)
    );

    always #5 clk = ~clk;

    assign d_in     = d_fb ? chain_q : d_val;
    assign scan_out = chain_q[N-1];

    // Chain shifts toward flop N-1 when enabled, else captures d
    always @(posedge clk) begin
        if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
        else         chain_q <= d_in;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full pattern, starting at a negedge in IDLE. Expected response is
    // whatever the chain's d inputs held at capture time.
    task automatic run_pattern(input logic [N-1:0] vec, input logic [N-1:0] dval,
                               input bit use_fb, input int bp, input bit pulse,
                               input bit hold, input logic [N-1:0] next_vec,
                               input bit rr_on);
        logic [N-1:0] exp_resp;
        exp_resp    = use_fb ? vec : dval;
        d_fb        = use_fb;
        d_val       = dval;
        start_vec   = vec;
        start_valid = 1'b1;
        resp_ready  = rr_on;
        chk1("accept_ready", start_ready, 1'b1);
        tick();
        if (hold) start_vec = next_vec;
        else begin
            start_valid = 1'b0;
            start_vec   = N'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            chk1("shift_en", scan_en, 1'b1);
            chk1("shift_in", scan_in, vec[N-1-i]);
            chk1("shift_rdy", start_ready, 1'b0);
            chk1("shift_busy", busy, 1'b1);
            tick();
        end
        chk1("cap_en", scan_en, 1'b0);
        chk1("cap_in", scan_in, 1'b0);
        chkv("cap_q", chain_q, vec);
        tick();
        d_val = ~dval;
        for (int i = 0; i < N; i++) begin
            chk1("unl_en", scan_en, 1'b1);
            chk1("unl_in", scan_in, 1'b0);
            chk1("unl_valid", resp_valid, 1'b0);
            if (pulse && i == 0) begin
                start_valid = 1'b1;
                start_vec   = '1;
            end
            tick();
            if (pulse && i == 0) start_valid = 1'b0;
        end
        chk1("done_valid", resp_valid, 1'b1);
        chkv("done_resp", resp_vec, exp_resp);
        chk1("done_en", scan_en, 1'b0);
        chk1("done_rdy", start_ready, 1'b0);
        chk1("done_busy", busy, 1'b1);
        for (int b = 0; b < bp; b++) begin
            resp_ready = 1'b0;
            tick();
            chk1("bp_valid", resp_valid, 1'b1);
            chkv("bp_resp", resp_vec, exp_resp);
            chk1("bp_en", scan_en, 1'b0);
            chk1("bp_rdy", start_ready, 1'b0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = rr_on;
        chk1("hs_valid", resp_valid, 1'b0);
        chk1("hs_rdy", start_ready, 1'b1);
        chk1("hs_busy", busy, 1'b0);
        chkv("hs_resp_held", resp_vec, exp_resp);
    endtask

    // Watchdog: the sequence is fixed-length, so this only fires on a hang
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        start_vec   = '0;
        resp_ready  = 1'b0;
        d_val       = '0;
        d_fb        = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        chk1("rst_en", scan_en, 1'b0);
        chk1("rst_in", scan_in, 1'b0);
        chk1("rst_rdy", start_ready, 1'b1);
        chk1("rst_valid", resp_valid, 1'b0);
        chkv("rst_resp", resp_vec, '0);
        chk1("rst_busy", busy, 1'b0);

        // Basic pattern with 5 cycles of backpressure
        run_pattern(3'b101, 3'b010, 1'b0, 5, 1'b0, 1'b0, 3'b000, 1'b0);
        // Load-only: d fed back from q
        run_pattern(3'b110, 3'b000, 1'b1, 0, 1'b0, 1'b0, 3'b000, 1'b0);
        // Request pulsed during unload must be ignored
        run_pattern(3'b001, 3'b100, 1'b0, 1, 1'b1, 1'b0, 3'b000, 1'b0);
        // The pulse must not have started anything
        tick();
        chk1("ign_busy", busy, 1'b0);
        // Back-to-back with start_valid and resp_ready held high
        run_pattern(3'b011, 3'b110, 1'b0, 0, 1'b0, 1'b1, 3'b100, 1'b1);
        run_pattern(3'b100, 3'b011, 1'b0, 0, 1'b0, 1'b0, 3'b000, 1'b1);
        resp_ready = 1'b0;

        // Reset held two edges in the middle of SHIFT
        start_vec   = 3'b111;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk1("mrst_en", scan_en, 1'b0);
        chk1("mrst_rdy", start_ready, 1'b1);
        chk1("mrst_valid", resp_valid, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        chkv("mrst_resp", resp_vec, '0);
        tick();
        chk1("mrst_idle", busy, 1'b0);

        // Random patterns
        for (int k = 0; k < 10; k++) begin
            run_pattern(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        1'b0, 3'b000, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_scan_test_ctrl
`default_nettype wire
